// File: rtl/sr_pkg.sv
// Shared command encodings and illegal-command policy codes for the SR flip-flop.
package sr_pkg;

  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RESET   = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_INVALID = 2'b11;

  localparam int POL_HOLD = 0;
  localparam int POL_CLR  = 1;
  localparam int POL_SET  = 2;
  localparam int POL_TOG  = 3;

  localparam int POL_MAX = POL_TOG;

endpackage

// File: rtl/sr_flip_flop_if.sv
// Command/state bundle of the SR flip-flop; err exists only when SR_ERR_FLAG_EN is defined.
interface sr_flip_flop_if;

  logic [1:0] sr;
  logic       q;
  logic       qb;
`ifdef SR_ERR_FLAG_EN
  logic       err;
`endif

`ifdef SR_ERR_FLAG_EN
  modport master (output sr, input q, input qb, input err);
  modport slave  (input sr, output q, output qb, output err);
`else
  modport master (output sr, input q, input qb);
  modport slave  (input sr, output q, output qb);
`endif

endinterface

// File: rtl/sr_next_state.sv
// Combinational next-state decode for the SR flip-flop, including the configurable
// resolution of the illegal S=R=1 command.
module sr_next_state
  import sr_pkg::*;
#(
  parameter int INVALID_POLICY = POL_HOLD
) (
  input  logic [1:0] sr,
  input  logic       q_cur,
  output logic       q_nxt,
  output logic       illegal
);

  if (INVALID_POLICY < 0 || INVALID_POLICY > POL_MAX) begin : g_bad_policy
    $error("sr_next_state: INVALID_POLICY %0d out of range 0..3", INVALID_POLICY);
  end

  // Value chosen for q when both S and R are asserted
  logic q_invalid;

  always_comb begin
    q_invalid = q_cur;
    case (INVALID_POLICY)
      POL_CLR: q_invalid = 1'b0;
      POL_SET: q_invalid = 1'b1;
      POL_TOG: q_invalid = ~q_cur;
      default: q_invalid = q_cur;
    endcase
  end

  always_comb begin
    q_nxt   = q_cur;
    illegal = 1'b0;
    case (sr)
      SR_HOLD:  q_nxt = q_cur;
      SR_RESET: q_nxt = 1'b0;
      SR_SET:   q_nxt = 1'b1;
      SR_INVALID: begin
        q_nxt   = q_invalid;
        illegal = 1'b1;
      end
      default:  q_nxt = q_cur;
    endcase
  end

endmodule

// File: rtl/sr_flip_flop.sv
// Clocked SR flip-flop with synchronous active-high reset and complementary output.
// Define SR_ERR_FLAG_EN to add the sticky illegal-command flag err.
module sr_flip_flop
  import sr_pkg::*;
#(
  parameter logic RST_VAL        = 1'b0,
  parameter int   INVALID_POLICY = POL_HOLD
) (
  input  logic           clk,
  input  logic           rst,
  sr_flip_flop_if.slave  bus
);

  logic q_reg;
  logic q_nxt;
  logic illegal;

  sr_next_state #(
    .INVALID_POLICY(INVALID_POLICY)
  ) u_next (
    .sr      (bus.sr),
    .q_cur   (q_reg),
    .q_nxt   (q_nxt),
    .illegal (illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= RST_VAL;
    end else begin
      q_reg <= q_nxt;
    end
  end

  // qb is derived from the register so it can never disagree with q
  assign bus.q  = q_reg;
  assign bus.qb = ~q_reg;

`ifdef SR_ERR_FLAG_EN
  logic err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (illegal) begin
      err_reg <= 1'b1;
    end
  end

  assign bus.err = err_reg;
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif

endmodule

// File: tb/tb_sr_flip_flop.sv
// Bench for sr_flip_flop: five instances covering every illegal-command policy and both reset values.
module tb_sr_flip_flop;

  localparam int       NDUT  = 5;
  localparam int       POLS [NDUT] = '{0, 1, 2, 3, 1};
  localparam bit [4:0] RVALS = 5'b10000;

  logic       clk;
  logic       rst;
  logic [1:0] sr;
  logic [NDUT-1:0] dq;
  logic [NDUT-1:0] dqb;
  logic [NDUT-1:0] derr;

  int checks;
  int errors;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    sr_flip_flop_if bus ();
    assign bus.sr = sr;
    sr_flip_flop #(
      .RST_VAL        (RVALS[g]),
      .INVALID_POLICY (POLS[g])
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
    assign dq[g]  = bus.q;
    assign dqb[g] = bus.qb;
`ifdef SR_ERR_FLAG_EN
    assign derr[g] = bus.err;
`else
    assign derr[g] = 1'b0;
`endif
  end

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Reference behaviour in terms of the S and R bits rather than command codes
  function automatic bit model_next(bit q, bit [1:0] cmd, int pol);
    bit s, r;
    s = cmd[1];
    r = cmd[0];
    if (s && r) begin
      if (pol == 1)      return 1'b0;
      else if (pol == 2) return 1'b1;
      else if (pol == 3) return !q;
      else               return q;
    end
    if (s) return 1'b1;
    if (r) return 1'b0;
    return q;
  endfunction

  bit mq [NDUT];
  bit merr;
  bit mvalid;

  initial begin
    mvalid = 1'b0;
    merr   = 1'b0;
    foreach (mq[i]) mq[i] = 1'b0;
  end

  // Per-cycle comparison of every instance against the model
  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (rst) mq[i] = RVALS[i];
      else     mq[i] = model_next(mq[i], sr, POLS[i]);
    end
    if (rst)             merr = 1'b0;
    else if (sr == 2'b11) merr = 1'b1;
    if (rst) mvalid = 1'b1;
    #1;
    if (mvalid) begin
      for (int i = 0; i < NDUT; i++) begin
        checks++;
        if (dq[i] !== mq[i]) begin
          errors++;
          $display("[TB] FAIL model_q dut%0d: got %b expected %b", i, dq[i], mq[i]);
        end
        checks++;
        if (dqb[i] !== !mq[i]) begin
          errors++;
          $display("[TB] FAIL model_qb dut%0d: got %b expected %b", i, dqb[i], !mq[i]);
        end
`ifdef SR_ERR_FLAG_EN
        checks++;
        if (derr[i] !== merr) begin
          errors++;
          $display("[TB] FAIL model_err dut%0d: got %b expected %b", i, derr[i], merr);
        end
`endif
      end
    end
  end

  typedef struct {
    bit       rst;
    bit [1:0] sr;
    bit [4:0] exp_q;
    bit       exp_err;
  } vec_t;

  // exp_q bit i is the hand-computed q of instance i after the edge
  vec_t vecs [18] = '{
    '{1'b1, 2'b10, 5'b10000, 1'b0},
    '{1'b0, 2'b00, 5'b10000, 1'b0},
    '{1'b0, 2'b01, 5'b00000, 1'b0},
    '{1'b0, 2'b10, 5'b11111, 1'b0},
    '{1'b0, 2'b00, 5'b11111, 1'b0},
    '{1'b0, 2'b11, 5'b00101, 1'b1},
    '{1'b0, 2'b11, 5'b01101, 1'b1},
    '{1'b0, 2'b00, 5'b01101, 1'b1},
    '{1'b0, 2'b00, 5'b01101, 1'b1},
    '{1'b1, 2'b00, 5'b10000, 1'b0},
    '{1'b0, 2'b10, 5'b11111, 1'b0},
    '{1'b1, 2'b10, 5'b10000, 1'b0},
    '{1'b0, 2'b10, 5'b11111, 1'b0},
    '{1'b0, 2'b01, 5'b00000, 1'b0},
    '{1'b0, 2'b01, 5'b00000, 1'b0},
    '{1'b0, 2'b11, 5'b01100, 1'b1},
    '{1'b0, 2'b11, 5'b00100, 1'b1},
    '{1'b1, 2'b11, 5'b10000, 1'b0}
  };

  task automatic applyStimulus(input bit r, input bit [1:0] cmd);
    @(negedge clk);
    rst = r;
    sr  = cmd;
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input int step, input bit [4:0] exp_q, input bit exp_err);
    bit [4:0] model_vec;
    for (int i = 0; i < NDUT; i++) model_vec[i] = mq[i];
    checks++;
    if (dq !== exp_q) begin
      errors++;
      $display("[TB] FAIL step%0d_q: got %b expected %b", step, dq, exp_q);
    end
    checks++;
    if (dqb !== ~exp_q) begin
      errors++;
      $display("[TB] FAIL step%0d_qb: got %b expected %b", step, dqb, ~exp_q);
    end
    checks++;
    if (model_vec !== exp_q) begin
      errors++;
      $display("[TB] FAIL step%0d_model: got %b expected %b", step, model_vec, exp_q);
    end
`ifdef SR_ERR_FLAG_EN
    checks++;
    if (derr !== {NDUT{exp_err}}) begin
      errors++;
      $display("[TB] FAIL step%0d_err: got %b expected %b", step, derr, {NDUT{exp_err}});
    end
`else
    if (exp_err && derr !== 5'b00000) begin
      $display("[TB] unexpected err activity with flag disabled");
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    sr     = 2'b00;
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].sr);
      checkOutput(k, vecs[k].exp_q, vecs[k].exp_err);
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
